// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [1:0] HALT_NONE   = 2'd0;
    localparam logic [1:0] HALT_EBREAK = 2'd1;
    localparam logic [1:0] HALT_WDOG   = 2'd2;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic redirect_valid;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE = 9'b0_0000_0000;

    // Every pipeline register frozen, no bubbles injected.
    function automatic hz_ctrl_t ctrl_freeze();
        hz_ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_hold     = 1'b1;
        c.if_id_hold  = 1'b1;
        c.id_ex_hold  = 1'b1;
        c.ex_mem_hold = 1'b1;
        return c;
    endfunction

    // Front end frozen while EX is busy; EX/MEM receives a bubble.
    function automatic hz_ctrl_t ctrl_mdu_hold();
        hz_ctrl_t c;
        c              = CTRL_IDLE;
        c.pc_hold      = 1'b1;
        c.if_id_hold   = 1'b1;
        c.id_ex_hold   = 1'b1;
        c.ex_mem_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forward-select for one ID source register; x0 never forwards.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW = DEF_REG_ADDR_WIDTH
) (
    input  logic [AW-1:0] rs,
    input  logic          ex_wen,
    input  logic [AW-1:0] ex_waddr,
    input  logic          ex_is_load,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_waddr,
    output logic [1:0]    sel
);

    // Youngest producer wins; a load in EX has no result yet.
    always_comb begin
        sel = FWD_REG;
        if (ex_wen && (ex_waddr != '0) && (ex_waddr == rs) && !ex_is_load) begin
            sel = FWD_EX;
        end else if (mem_wen && (mem_waddr != '0) && (mem_waddr == rs)) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int PC_WIDTH       = 64,
    parameter int WDOG_W         = 8,
    parameter int WDOG_MAX       = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_wen,
    input  logic [REG_ADDR_WIDTH-1:0] ex_waddr,
    input  logic                      ex_is_load,
    input  logic                      mem_wen,
    input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
    input  logic                      ex_redirect,
    input  logic [PC_WIDTH-1:0]       ex_target,
    input  logic                      ex_mdu_start,
    input  logic                      mdu_done,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    input  logic                      wb_ebreak,
    output logic                      pc_hold,
    output logic                      if_id_hold,
    output logic                      id_ex_hold,
    output logic                      ex_mem_hold,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      mem_wb_flush,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      redirect_valid,
    output logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      halt,
    output logic [1:0]                halt_code
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_flush_events,
    output logic [31:0]               perf_load_use
`endif
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);

    hz_state_e           state_r, state_ctrl_nxt, state_nxt;
    logic [1:0]          halt_code_r, halt_code_ctrl_nxt, halt_code_nxt;
    logic [WDOG_W-1:0]   wdog_r, wdog_nxt;
    logic                wdog_hit_s;
    logic [PC_WIDTH-1:0] redirect_pc_r;
    hz_ctrl_t            ctrl_s;
    logic                mem_stall_s;
    logic                load_use_s;

    pipe_hazard_ctrl_fwd_unit #(.AW(REG_ADDR_WIDTH)) u_fwd_a (
        .rs(id_rs1), .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .sel(fwd_a_sel)
    );

    pipe_hazard_ctrl_fwd_unit #(.AW(REG_ADDR_WIDTH)) u_fwd_b (
        .rs(id_rs2), .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .sel(fwd_b_sel)
    );

    assign mem_stall_s = mem_req && !mem_ready;
    assign load_use_s  = ex_is_load && ex_wen && (ex_waddr != '0) &&
                         ((id_rs1_used && (id_rs1 == ex_waddr)) ||
                          (id_rs2_used && (id_rs2 == ex_waddr)));

    // Pipeline control decode and FSM next state (watchdog applied separately).
    always_comb begin
        ctrl_s             = CTRL_IDLE;
        state_ctrl_nxt     = state_r;
        halt_code_ctrl_nxt = halt_code_r;
        if (state_r == ST_HALT) begin
            ctrl_s = ctrl_freeze();
        end else if (wb_ebreak) begin
            ctrl_s             = ctrl_freeze();
            state_ctrl_nxt     = ST_HALT;
            halt_code_ctrl_nxt = HALT_EBREAK;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        ctrl_s              = ctrl_freeze();
                        ctrl_s.mem_wb_flush = 1'b1;
                    end else if (ex_mdu_start) begin
                        ctrl_s         = ctrl_mdu_hold();
                        state_ctrl_nxt = ST_MDU_WAIT;
                    end else if (ex_redirect) begin
                        ctrl_s.redirect_valid = 1'b1;
                        ctrl_s.if_id_flush    = 1'b1;
                        ctrl_s.id_ex_flush    = 1'b1;
                    end else if (load_use_s) begin
                        ctrl_s.pc_hold     = 1'b1;
                        ctrl_s.if_id_hold  = 1'b1;
                        ctrl_s.id_ex_flush = 1'b1;
                    end else begin
                        ctrl_s = CTRL_IDLE;
                    end
                end
                ST_MDU_WAIT: begin
                    if (mdu_done) begin
                        state_ctrl_nxt = ST_RUN;
                        if (mem_stall_s) begin
                            ctrl_s              = ctrl_freeze();
                            ctrl_s.mem_wb_flush = 1'b1;
                        end else begin
                            ctrl_s = CTRL_IDLE;
                        end
                    end else begin
                        ctrl_s = ctrl_mdu_hold();
                        if (mem_stall_s) begin
                            ctrl_s.ex_mem_hold  = 1'b1;
                            ctrl_s.mem_wb_flush = 1'b1;
                        end else begin
                            ctrl_s.ex_mem_hold  = 1'b0;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: freeze one cycle and resume.
                    ctrl_s         = ctrl_freeze();
                    state_ctrl_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Stall watchdog: counts consecutive held cycles, saturating.
    always_comb begin
        wdog_nxt = '0;
        if ((state_r != ST_HALT) && ctrl_s.pc_hold) begin
            wdog_nxt = (wdog_r == WDOG_LIMIT) ? wdog_r : (wdog_r + WDOG_W'(1));
        end else begin
            wdog_nxt = '0;
        end
        wdog_hit_s = (state_r != ST_HALT) && !wb_ebreak && (wdog_nxt == WDOG_LIMIT);
    end

    // Final next state: a watchdog expiry overrides the control decode.
    always_comb begin
        state_nxt     = state_ctrl_nxt;
        halt_code_nxt = halt_code_ctrl_nxt;
        if (wdog_hit_s) begin
            state_nxt     = ST_HALT;
            halt_code_nxt = HALT_WDOG;
        end else begin
            state_nxt     = state_ctrl_nxt;
            halt_code_nxt = halt_code_ctrl_nxt;
        end
    end

    // State, halt code, watchdog and last redirect target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            halt_code_r   <= HALT_NONE;
            wdog_r        <= '0;
            redirect_pc_r <= '0;
        end else begin
            state_r     <= state_nxt;
            halt_code_r <= halt_code_nxt;
            wdog_r      <= wdog_nxt;
            if (ctrl_s.redirect_valid) begin
                redirect_pc_r <= ex_target;
            end
        end
    end

    assign pc_hold        = ctrl_s.pc_hold;
    assign if_id_hold     = ctrl_s.if_id_hold;
    assign id_ex_hold     = ctrl_s.id_ex_hold;
    assign ex_mem_hold    = ctrl_s.ex_mem_hold;
    assign if_id_flush    = ctrl_s.if_id_flush;
    assign id_ex_flush    = ctrl_s.id_ex_flush;
    assign ex_mem_flush   = ctrl_s.ex_mem_flush;
    assign mem_wb_flush   = ctrl_s.mem_wb_flush;
    assign redirect_valid = ctrl_s.redirect_valid;
    assign redirect_pc    = ctrl_s.redirect_valid ? ex_target : redirect_pc_r;
    assign halt           = (state_r == ST_HALT);
    assign halt_code      = halt_code_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_r, perf_flush_r, perf_lu_r;
    logic        lu_bubble_s;

    // id_ex_flush without a redirect can only be a load-use bubble.
    assign lu_bubble_s = ctrl_s.id_ex_flush && !ctrl_s.redirect_valid;

    // Event counters, frozen while halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
            perf_lu_r    <= 32'd0;
        end else if (state_r != ST_HALT) begin
            perf_stall_r <= perf_stall_r + {31'd0, ctrl_s.pc_hold};
            perf_flush_r <= perf_flush_r + {31'd0, ctrl_s.redirect_valid};
            perf_lu_r    <= perf_lu_r + {31'd0, lu_bubble_s};
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_flush_events = perf_flush_r;
    assign perf_load_use     = perf_lu_r;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Drives hold/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Drives operand-forward selects for the ID stage and branch/jump redirect to IF.
- Sequences multi-cycle MDU operations, data-memory wait states, ebreak halt and a stall watchdog.

Parameters:
REG_ADDR_WIDTH, 5, register address width
PC_WIDTH, 64, program counter width
WDOG_W, 8, watchdog counter width
WDOG_MAX, 200, consecutive stalled cycles that force HALT (must be < 2**WDOG_W)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_rs1  in  REG_ADDR_WIDTH  ID source 1 address
id_rs2  in  REG_ADDR_WIDTH  ID source 2 address
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_wen  in  1  EX-stage (ID/EX output) register write enable
ex_waddr  in  REG_ADDR_WIDTH  EX-stage destination
ex_is_load  in  1  EX-stage instruction is a load
mem_wen  in  1  MEM-stage write enable
mem_waddr  in  REG_ADDR_WIDTH  MEM-stage destination
ex_redirect  in  1  EX resolved taken branch, jal or jalr
ex_target  in  PC_WIDTH  redirect target
ex_mdu_start  in  1  EX issues multi-cycle mul/div (pulse)
mdu_done  in  1  MDU result valid (pulse)
mem_req  in  1  MEM-stage data-memory request
mem_ready  in  1  data memory accepts/completes request
wb_ebreak  in  1  ebreak retiring in WB
pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1 each  freeze register
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (NOP, wen=0)
fwd_a_sel, fwd_b_sel  out  2  0=regfile, 1=EX result, 2=MEM result
redirect_valid  out  1  load ex_target into PC
redirect_pc  out  PC_WIDTH  redirect address
halt  out  1  core halted
halt_code  out  2  0=none, 1=ebreak, 2=watchdog

Behaviour:
- Reset: state RUN, stall counter 0, all hold/flush outputs 0, redirect_valid 0, redirect_pc 0, halt 0, halt_code 0. Reset asserted mid-operation aborts MDU_WAIT or HALT immediately.
- Forwarding (combinational, per source):
  - Match EX when ex_wen, ex_waddr!=0, ex_waddr==rs and !ex_is_load: sel=1.
  - Otherwise match MEM when mem_wen, mem_waddr!=0, mem_waddr==rs: sel=2.
  - Otherwise sel=0. x0 never forwards.
- load_use: ex_is_load, ex_wen, ex_waddr!=0, and ex_waddr equals a used rs.
- mem_stall: mem_req & !mem_ready.
- Control priority within RUN, highest first:
  1. mem_stall: all holds=1, mem_wb_flush=1. Redirect and MDU start are deferred because EX is frozen.
  2. ex_mdu_start: go to MDU_WAIT. Same cycle: pc/if_id/id_ex hold=1, ex_mem_flush=1.
  3. ex_redirect: redirect_valid=1, redirect_pc=ex_target, if_id_flush=1, id_ex_flush=1. Any load_use in the same cycle is ignored.
  4. load_use: pc_hold=1, if_id_hold=1, id_ex_flush=1 for exactly one cycle. Next cycle the load is in MEM and sel=2.
- MDU_WAIT:
  - pc/if_id/id_ex hold=1, ex_mem_flush=1 every cycle.
  - On mdu_done, go to RUN and release holds in the same cycle; ex_mem_flush=0 that cycle.
  - mem_stall during MDU_WAIT additionally asserts ex_mem_hold and mem_wb_flush.
- ex_mdu_start and ex_redirect together: illegal; mdu_start wins.
- wb_ebreak, any state: next state HALT, halt_code=1. It takes precedence over all RUN rules in that cycle.
- HALT is absorbing until reset: all holds=1, all flushes=0, halt=1, redirect_valid=0.
- Watchdog:
  - Counter increments on each cycle in which pc_hold=1 and state!=HALT; clears otherwise.
  - On reaching WDOG_MAX: HALT with halt_code=2.
  - Saturates; never wraps.
- redirect_pc holds its last value when redirect_valid=0.

Optional Feature:
HAZARD_PERF_CNT_EN adds 32-bit outputs perf_stall_cycles, perf_flush_events and perf_load_use.
- perf_stall_cycles: cycles with pc_hold.
- perf_flush_events: redirect cycles.
- perf_load_use: load-use bubbles.
- All reset to 0, wrap at 2^32, and freeze in HALT.
Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/defines: FSM state encoding (RUN=2'd0, MDU_WAIT=2'd1, HALT=2'd2), FWD_REG/FWD_EX/FWD_MEM=2'd0/1/2, HALT_NONE/EBREAK/WDOG codes. Reuse the existing REG_ADDR_WIDTH define.
- One natural sub-module: fwd_unit (combinational forward-select for one source), instantiated twice.

Test Plan:
- ld x5 in EX (ex_is_load=1, ex_waddr=5), ID add using rs1=5 -> one cycle pc_hold=1, if_id_hold=1, id_ex_flush=1; next cycle fwd_a_sel=2.
- ex_wen=1, ex_waddr=3, mem_wen=1, mem_waddr=3, rs2=3 used -> fwd_b_sel=1. With waddr=0 on both -> fwd_b_sel=0.
- ex_redirect=1, ex_target=0x8000_0040, concurrent load_use -> redirect_valid=1, redirect_pc=0x8000_0040, if_id_flush=id_ex_flush=1, no hold.
- ex_mdu_start pulse, mdu_done after 33 cycles -> holds high 33 cycles with ex_mem_flush=1, RUN on cycle 34 with holds low.
- mem_req=1, mem_ready=0 for WDOG_MAX cycles -> halt=1, halt_code=2. Separately, wb_ebreak=1 -> halt next cycle, halt_code=1. rst_n low clears both.
- mem_stall during MDU_WAIT, then mdu_done -> ex_mem_hold=1 while stalled, exit only after mdu_done.
